sid_svf_mixer: RTL

SID_SVF_MIXER -- requirements
Module: sid_svf_mixer

---
 rtl/sid_pkg.sv | 29 ++
 rtl/sid_svf_datapath.sv | 74 +++++++
 rtl/sid_svf_mixer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sid_pkg.sv
// sid_pkg: shared sequencer states, resonance table and coefficient shifts for the SID SVF mixer.
`default_nettype none

package sid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HP   = 3'd1,
    ST_LP   = 3'd2,
    ST_BP   = 3'd3,
    ST_MIX  = 3'd4,
    ST_VOL  = 3'd5,
    ST_OUT  = 3'd6
  } sid_state_e;

  localparam int FC_SHIFT  = 6;
  localparam int RES_SHIFT = 10;
  localparam int CUT_SHIFT = 20;
  localparam int VOL_SHIFT = 4;

  // floor(1024 / (0.707 + res/15)): feedback gain falls as resonance rises
  localparam logic [10:0] RES_LUT [16] = '{
    11'h5A8, 11'h52B, 11'h4C2, 11'h468, 11'h41B, 11'h3D8, 11'h39D, 11'h368,
    11'h339, 11'h30F, 11'h2E9, 11'h2C6, 11'h2A7, 11'h28A, 11'h270, 11'h257
  };

endpackage

`default_nettype wire

// File: rtl/sid_svf_datapath.sv
// sid_svf_datapath: state-variable filter registers and the single multiplier shared with volume scaling.
`default_nettype none

module sid_svf_datapath
  import sid_pkg::*;
#(
  parameter int ACCW = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   step,
  input  sid_state_e             state,
  input  logic [10:0]            reg_fc,
  input  logic [3:0]             res,
  input  logic signed [ACCW-1:0] filt_in,
  input  logic signed [ACCW-1:0] acc,
  input  logic [3:0]             vol,
  output logic signed [ACCW-1:0] high,
  output logic signed [ACCW-1:0] band,
  output logic signed [ACCW-1:0] low,
  output logic signed [ACCW-1:0] prod
);

  logic [16:0]            coef_c;
  logic signed [ACCW-1:0] op_a;
  logic signed [ACCW-1:0] op_b;

  assign coef_c = {reg_fc, {FC_SHIFT{1'b0}}};

  // One product per sequencer step; the state picks which pair feeds it
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state)
      ST_HP: begin
        op_a = ACCW'(RES_LUT[res]);
        op_b = band;
      end
      ST_LP: begin
        op_a = ACCW'(coef_c);
        op_b = band;
      end
      ST_BP: begin
        op_a = ACCW'(coef_c);
        op_b = high;
      end
      ST_VOL: begin
        op_a = acc;
        op_b = ACCW'(vol);
      end
      default: ;
    endcase
  end

  assign prod = op_a * op_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high <= '0;
      band <= '0;
      low  <= '0;
    end else if (step) begin
      case (state)
        ST_HP:   high <= (prod >>> RES_SHIFT) - low - filt_in;
        ST_LP:   low  <= low - (prod >>> CUT_SHIFT);
        ST_BP:   band <= band - (prod >>> CUT_SHIFT);
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sid_svf_mixer.sv
// sid_svf_mixer: SID-style voice mixer with shared SVF, volume and valid/ready output.
// Define SID_SVF_SAT_EN to clamp the output sample instead of wrapping it.
`default_nettype none

module sid_svf_mixer
  import sid_pkg::*;
#(
  parameter int NVOICE = 3,
  parameter int SW     = 12,
  parameter int ACCW   = 32,
  parameter int OUTW   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_enable,
  input  logic [NVOICE*SW-1:0] voice_in,
  input  logic [NVOICE-1:0]    filt_sel,
  input  logic [NVOICE-1:0]    mute,
  input  logic [10:0]          reg_fc,
  input  logic [3:0]           res,
  input  logic [2:0]           mode,
  input  logic [3:0]           vol,
  output logic [OUTW-1:0]      out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun
);

  localparam int VCW = (NVOICE > 1) ? $clog2(NVOICE) : 1;

  sid_state_e             state;
  sid_state_e             state_nxt;
  logic [VCW-1:0]         vcnt;
  logic [VCW-1:0]         vcnt_nxt;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] filt_sum;
  logic signed [ACCW-1:0] filt_in;
  logic signed [ACCW-1:0] mode_sum;
  logic signed [ACCW-1:0] filtered;
  logic signed [ACCW-1:0] mix_base;
  logic signed [ACCW-1:0] voice_add;
  logic signed [ACCW-1:0] high;
  logic signed [ACCW-1:0] band;
  logic signed [ACCW-1:0] low;
  logic signed [ACCW-1:0] prod;
  logic [OUTW-1:0]        out_next;

  sid_svf_datapath #(
    .ACCW (ACCW)
  ) u_datapath (
    .clk     (clk),
    .rst_n   (rst_n),
    .step    (clk_enable),
    .state   (state),
    .reg_fc  (reg_fc),
    .res     (res),
    .filt_in (filt_in),
    .acc     (acc),
    .vol     (vol),
    .high    (high),
    .band    (band),
    .low     (low),
    .prod    (prod)
  );

  always_comb begin
    filt_sum = '0;
    for (int k = 0; k < NVOICE; k++) begin
      if (filt_sel[k]) filt_sum = filt_sum + ACCW'(voice_in[k*SW +: SW]);
    end
    filt_in = filt_sum <<< 1;
  end

  // Only the voice addressed by the counter contributes on each MIX step
  always_comb begin
    voice_add = '0;
    for (int k = 0; k < NVOICE; k++) begin
      if (vcnt == VCW'(k) && !filt_sel[k] && !mute[k])
        voice_add = ACCW'(voice_in[k*SW +: SW]);
    end
  end

  always_comb begin
    mode_sum = '0;
    if (mode[2]) mode_sum = mode_sum + high;
    if (mode[1]) mode_sum = mode_sum + band;
    if (mode[0]) mode_sum = mode_sum + low;
    filtered = mode_sum >>> 1;
    mix_base = (vcnt == '0) ? filtered : acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      vcnt  <= '0;
    end else begin
      state <= state_nxt;
      vcnt  <= vcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    vcnt_nxt  = vcnt;
    if (clk_enable) begin
      case (state)
        ST_IDLE: state_nxt = ST_HP;
        ST_HP:   state_nxt = ST_LP;
        ST_LP:   state_nxt = ST_BP;
        ST_BP: begin
          state_nxt = ST_MIX;
          vcnt_nxt  = '0;
        end
        ST_MIX: begin
          if (vcnt == VCW'(NVOICE - 1)) begin
            state_nxt = ST_VOL;
            vcnt_nxt  = '0;
          end else begin
            vcnt_nxt = vcnt + VCW'(1);
          end
        end
        ST_VOL:  state_nxt = ST_OUT;
        ST_OUT:  state_nxt = ST_IDLE;
        default: begin
          state_nxt = ST_IDLE;
          vcnt_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clk_enable) begin
      case (state)
        ST_MIX:  acc <= mix_base + voice_add;
        ST_VOL:  acc <= prod >>> VOL_SHIFT;
        default: ;
      endcase
    end
  end

`ifdef SID_SVF_SAT_EN
  localparam logic signed [ACCW-1:0] OUT_BIAS = ACCW'({1'b1, {(OUTW-1){1'b0}}});
  localparam logic signed [ACCW-1:0] OUT_MAX  = ACCW'({OUTW{1'b1}});
  logic signed [ACCW-1:0] result;

  always_comb begin
    result = acc + OUT_BIAS;
    if (result[ACCW-1])      out_next = '0;
    else if (result > OUT_MAX) out_next = '1;
    else                     out_next = result[OUTW-1:0];
  end
`else
  localparam logic [OUTW-1:0] OUT_BIAS = {1'b1, {(OUTW-1){1'b0}}};

  always_comb begin
    out_next = acc[OUTW-1:0] + OUT_BIAS;
  end
`endif

  // Consumer handshake runs every clock; only the load is gated by the sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (clk_enable && state == ST_OUT) begin
        out_data  <= out_next;
        out_valid <= 1'b1;
        overrun   <= out_valid & ~out_ready;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
